// File: rtl/elevator_ctrl.sv
// Multi-floor elevator controller: latches floor calls, serves them in SCAN order,
// times travel and door dwell, and drives the red/green boarding lamps.
module elevator_ctrl #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic               r,
  output logic               g
);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  localparam int TT_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DT_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TT_W-1:0] TT_LAST = TT_W'(TRAVEL_CYC - 1);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DOOR_CYC - 1);

  state_t              state, state_nxt;
  logic [FLOOR_W-1:0]  floor_nxt, arr_f;
  logic                dir_nxt;
  logic [TT_W-1:0]     ttmr, ttmr_nxt;
  logic [DT_W-1:0]     dtmr, dtmr_nxt;
  logic [FLOORS-1:0]   pending_nxt, clr, hold;
  logic                here, above, below;

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i > int'(f)) hit = hit | v[i];
    return hit;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (i < int'(f)) hit = hit | v[i];
    return hit;
  endfunction

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  // State and datapath registers; reset aborts any move or door cycle outright
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      floor   <= '0;
      dir_up  <= 1'b1;
      pending <= '0;
      ttmr    <= '0;
      dtmr    <= '0;
    end else begin
      state   <= state_nxt;
      floor   <= floor_nxt;
      dir_up  <= dir_nxt;
      pending <= pending_nxt;
      ttmr    <= ttmr_nxt;
      dtmr    <= dtmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    floor_nxt = floor;
    dir_nxt   = dir_up;
    ttmr_nxt  = ttmr;
    dtmr_nxt  = dtmr;
    clr       = '0;
    hold      = '0;
    here      = pending[floor];
    above     = any_above(pending, floor);
    below     = any_below(pending, floor);
    arr_f     = dir_up ? floor + 1'b1 : floor - 1'b1;

    case (state)
      IDLE: begin
        if (here) begin
          state_nxt = DOOR;
          clr       = onehot(floor);
          dtmr_nxt  = '0;
        end else if (above && (dir_up || !below)) begin
          dir_nxt   = 1'b1;
          state_nxt = MOVE;
          ttmr_nxt  = '0;
        end else if (below) begin
          dir_nxt   = 1'b0;
          state_nxt = MOVE;
          ttmr_nxt  = '0;
        end
      end
      MOVE: begin
        if (ttmr == TT_LAST) begin
          floor_nxt = arr_f;
          ttmr_nxt  = '0;
          // A call arriving on the same edge as the car still stops it here
          if (pending[arr_f] | req[arr_f]) begin
            state_nxt = DOOR;
            clr       = onehot(arr_f);
            dtmr_nxt  = '0;
          end else if (dir_up ? any_above(pending, arr_f) : any_below(pending, arr_f)) begin
            state_nxt = MOVE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          ttmr_nxt = ttmr + 1'b1;
        end
      end
      DOOR: begin
        // Pressing the current floor's button holds the door instead of queueing a call
        if (req[floor]) begin
          hold     = onehot(floor);
          dtmr_nxt = '0;
        end else if (dtmr == DT_LAST) begin
          state_nxt = IDLE;
        end else begin
          dtmr_nxt = dtmr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    pending_nxt = (pending | (req & ~hold)) & ~clr;
  end

  always_comb begin
    moving    = (state == MOVE);
    door_open = (state == DOOR);
    g         = door_open;
    r         = ~door_open;
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl (8 floors, 4-cycle travel, 6-cycle door):
// table-driven single calls plus hand sequences for SCAN, door-hold and async reset.
module tb_elevator_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [2:0] floor;
  logic       dir_up, moving, door_open, r, g;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] fl;
    int         move;
    int         door;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] rq;
    logic [2:0] fl;
    int         move;
    int         door;
    int         lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[4];

  elevator_ctrl #(.FLOORS(8), .FLOOR_W(3), .TRAVEL_CYC(4), .DOOR_CYC(6)) dut (
    .clk(clk), .reset(reset), .req(req), .floor(floor), .dir_up(dir_up),
    .moving(moving), .door_open(door_open), .pending(pending), .r(r), .g(g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    sb.delete();
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  // Follow the car to its next door opening and compare against the scoreboard head.
  task automatic serve(input int inj_fl, input logic [7:0] inj_rq, input int inj_door);
    int mv, dr, lat;
    bit done_inj;
    logic [2:0] dfl;
    exp_t e;
    mv = 0; dr = 0; lat = 0; done_inj = 0;
    while (!door_open && lat < 300) begin
      step();
      lat++;
      req = '0;
      if (moving) begin
        mv++;
        if (!done_inj && inj_fl >= 0 && int'(floor) == inj_fl) begin
          req = inj_rq;
          done_inj = 1;
        end
      end
    end
    req = '0;
    chk("door_reached", int'(door_open), 1);
    if (!door_open) return;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e   = sb.pop_front();
    dfl = floor;
    chk("door_floor", int'(dfl), int'(e.fl));
    chk("latency", lat, e.lat);
    chk("move_cycles", mv, e.move);
    chk("green_open", int'(g), 1);
    chk("red_open", int'(r), 0);
    while (door_open && dr < 300) begin
      if (dr == inj_door) req = 8'd1 << dfl;
      step();
      dr++;
      req = '0;
      if (dr == inj_door + 1) chk("hold_not_latched", int'(pending[dfl]), 0);
    end
    chk("door_cycles", dr, e.door);
    chk("red_closed", int'(r), 1);
    chk("green_closed", int'(g), 0);
    chk("served_cleared", int'(pending[dfl]), 0);
  endtask

  initial begin
    vt[0] = '{rq: 8'h01, fl: 3'd0, move: 0,  door: 6, lat: 1};
    vt[1] = '{rq: 8'h08, fl: 3'd3, move: 12, door: 6, lat: 13};
    vt[2] = '{rq: 8'h80, fl: 3'd7, move: 28, door: 6, lat: 29};
    vt[3] = '{rq: 8'h02, fl: 3'd1, move: 4,  door: 6, lat: 5};

    // Held in reset with every button pressed
    reset = 1'b0;
    req   = 8'hFF;
    repeat (3) begin
      step();
      chk("rst_floor", int'(floor), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_r", int'(r), 1);
      chk("rst_g", int'(g), 0);
      chk("rst_dir", int'(dir_up), 1);
    end
    reset = 1'b1;
    step();
    chk("release_latch", int'(pending), 8'hFF);
    req   = '0;
    reset = 1'b0;
    #1;
    chk("async_clear_pending", int'(pending), 0);

    // Single calls from an idle car at floor 0
    for (int i = 0; i < 4; i++) begin
      do_reset();
      req = vt[i].rq;
      step();
      req = '0;
      chk("latched", int'(pending), int'(vt[i].rq));
      sb.push_back('{fl: vt[i].fl, move: vt[i].move, door: vt[i].door, lat: vt[i].lat});
      serve(-1, 8'h00, -1);
    end

    // Two calls in one cycle both latch and are served upward in order
    do_reset();
    req = 8'h28;
    step();
    req = '0;
    chk("multi_latch", int'(pending), 8'h28);
    sb.push_back('{fl: 3'd3, move: 12, door: 6, lat: 13});
    sb.push_back('{fl: 3'd5, move: 8,  door: 6, lat: 9});
    serve(-1, 8'h00, -1);
    serve(-1, 8'h00, -1);

    // SCAN: a call behind the car waits until the upward sweep finishes
    do_reset();
    req = 8'h40;
    step();
    req = '0;
    sb.push_back('{fl: 3'd6, move: 24, door: 6, lat: 25});
    sb.push_back('{fl: 3'd1, move: 20, door: 6, lat: 21});
    serve(4, 8'h02, -1);
    chk("scan_pending_behind", int'(pending), 8'h02);
    chk("scan_dir_before", int'(dir_up), 1);
    serve(-1, 8'h00, -1);
    chk("scan_dir_after", int'(dir_up), 0);

    // Door-hold at floor 2
    do_reset();
    req = 8'h04;
    step();
    req = '0;
    sb.push_back('{fl: 3'd2, move: 8, door: 11, lat: 9});
    serve(-1, 8'h00, 4);

    // Asynchronous reset between floors 2 and 3
    do_reset();
    req = 8'h20;
    step();
    req = '0;
    begin
      int n;
      n = 0;
      while (!(moving && floor == 3'd2) && n < 100) begin
        step();
        n++;
      end
      chk("reach_floor2", int'(moving && floor == 3'd2), 1);
    end
    #3;
    reset = 1'b0;
    #1;
    chk("abort_moving", int'(moving), 0);
    chk("abort_floor", int'(floor), 0);
    chk("abort_pending", int'(pending), 0);
    chk("abort_r", int'(r), 1);
    chk("abort_g", int'(g), 0);
    chk("abort_dir", int'(dir_up), 1);
    #22;
    reset = 1'b1;
    step();
    repeat (3) step();
    chk("post_floor", int'(floor), 0);
    chk("post_pending", int'(pending), 0);
    chk("post_moving", int'(moving), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
